// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM measurement path.
//   cap_state_e : capture FSM states
//   DefaultCntW : default counter / result width
//   TimeoutCnt  : stuck-level threshold (all ones) at the default width
package pwm_pkg;

  localparam int unsigned DefaultCntW = 8;

  localparam logic [DefaultCntW-1:0] TimeoutCnt = '1;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeas
  } cap_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchroniser and edge detector for an asynchronous PWM input.
//   clk, rst_n : clock, asynchronous active-low reset
//   pwm_in     : raw (possibly asynchronous) waveform
//   lvl        : synchronised level
//   rise, fall : single-cycle strobes on the synchronised level
module pwm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      lvl_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      lvl_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~lvl_d_q;
  assign fall = ~lvl & lvl_d_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time measurement, rising edge to rising edge.
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable                : 1 = measure, 0 = idle with counters and result cleared
//   pwm_in                : waveform under test (may be asynchronous)
//   meas_valid/meas_ready : result handshake
//   period, high_time     : measurement in clk cycles (0 on timeout)
//   timeout, stuck_level  : stuck-level report and the level it was stuck at
//   overrun               : sticky, an unconsumed result was overwritten
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = DefaultCntW,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout,
  output logic             stuck_level,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic lvl, rise, fall;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .lvl   (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic             fell_q, fell_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             timeout_q, timeout_d;
  logic             stuck_q, stuck_d;
  logic             overrun_q, overrun_d;

  logic             capture;
  logic [CNT_W-1:0] cap_period, cap_high;
  logic             cap_timeout, cap_stuck;

  always_comb begin
    state_d     = state_q;
    p_cnt_d     = p_cnt_q;
    h_cnt_d     = h_cnt_q;
    fell_d      = fell_q;
    valid_d     = valid_q;
    period_d    = period_q;
    high_d      = high_q;
    timeout_d   = timeout_q;
    stuck_d     = stuck_q;
    overrun_d   = overrun_q;
    capture     = 1'b0;
    cap_period  = '0;
    cap_high    = '0;
    cap_timeout = 1'b0;
    cap_stuck   = 1'b0;

    if (!enable) begin
      state_d   = StIdle;
      p_cnt_d   = '0;
      h_cnt_d   = '0;
      fell_d    = 1'b0;
      valid_d   = 1'b0;
      period_d  = '0;
      high_d    = '0;
      timeout_d = 1'b0;
      stuck_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // p_cnt counts cycles spent in ARM, starting at 1 on entry
          state_d = StArm;
          p_cnt_d = CntOne;
          h_cnt_d = '0;
        end
        StArm: begin
          if (rise) begin
            // first edge only starts the measurement
            state_d = StMeas;
            p_cnt_d = CntOne;
            h_cnt_d = CntOne;
            fell_d  = 1'b0;
          end else if (p_cnt_q == CntMax) begin
            capture     = 1'b1;
            cap_timeout = 1'b1;
            cap_stuck   = lvl;
            p_cnt_d     = CntOne;
          end else begin
            p_cnt_d = p_cnt_q + CntOne;
          end
        end
        StMeas: begin
          // timeout wins over a coincident rise so a counter never exceeds all-ones
          if (p_cnt_q == CntMax) begin
            capture     = 1'b1;
            cap_timeout = 1'b1;
            cap_stuck   = lvl;
            state_d     = StArm;
            p_cnt_d     = CntOne;
            h_cnt_d     = '0;
          end else if (rise) begin
            capture    = 1'b1;
            cap_period = p_cnt_q;
            cap_high   = h_cnt_q;
            p_cnt_d    = CntOne;
            h_cnt_d    = CntOne;
            fell_d     = 1'b0;
          end else begin
            p_cnt_d = p_cnt_q + CntOne;
            if (fall) fell_d = 1'b1;
            if (lvl && !fell_q) h_cnt_d = h_cnt_q + CntOne;
          end
        end
        default: state_d = StIdle;
      endcase

      if (capture) begin
        valid_d   = 1'b1;
        period_d  = cap_period;
        high_d    = cap_high;
        timeout_d = cap_timeout;
        stuck_d   = cap_stuck;
        if (valid_q && !meas_ready) overrun_d = 1'b1;
      end else if (valid_q && meas_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      p_cnt_q   <= '0;
      h_cnt_q   <= '0;
      fell_q    <= 1'b0;
      valid_q   <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_cnt_q   <= p_cnt_d;
      h_cnt_q   <= h_cnt_d;
      fell_q    <= fell_d;
      valid_q   <= valid_d;
      period_q  <= period_d;
      high_q    <= high_d;
      timeout_q <= timeout_d;
      stuck_q   <= stuck_d;
      overrun_q <= overrun_d;
    end
  end

  assign meas_valid  = valid_q;
  assign period      = period_q;
  assign high_time   = high_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table of periodic sources, hand-written handshake /
// enable / reset sequences, and random pulse trains against a pulse-level model.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int S  = 2;
  localparam int TO = int'(TimeoutCnt);  // 255

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       pwm_in = 1'b0;
  logic       meas_ready = 1'b0;
  logic       meas_valid;
  logic [7:0] period, high_time;
  logic       timeout, stuck_level, overrun;

  pwm_capture #(
    .CNT_W      (8),
    .SYNC_STAGES(S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .period     (period),
    .high_time  (high_time),
    .timeout    (timeout),
    .stuck_level(stuck_level),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Periodic source: high while phase < duty, phase advances each clock.
  bit src_on = 1'b0;
  int freq = 10, duty = 3, phase = 0;

  typedef struct {
    int p;
    int h;
    int to;
  } res_t;

  res_t got_q[$];
  res_t exp_q[$];
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && meas_valid && meas_ready)
      got_q.push_back('{int'(period), int'(high_time), int'(timeout)});
  end

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (src_on) begin
      phase  = (phase + 1 == freq) ? 0 : phase + 1;
      pwm_in = (phase < duty);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!meas_valid && n < 600) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    src_on = 1'b0;
    pwm_in = 1'b0;
    enable = 1'b0;
    rst_n  = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  // Starts the source at phase 0 together with enable (this is "edge 0").
  task automatic start_src(input int f, input int d);
    freq   = f;
    duty   = d;
    phase  = 0;
    pwm_in = (0 < d);
    src_on = 1'b1;
    enable = 1'b1;
  endtask

  task automatic chk_res(input string tag, input int p, input int h, input int to, input int st);
    chk({tag, " period"}, int'(period), p);
    chk({tag, " high_time"}, int'(high_time), h);
    chk({tag, " timeout"}, int'(timeout), to);
    chk({tag, " stuck_level"}, int'(stuck_level), st);
  endtask

  typedef struct {
    int freq;
    int duty;
    int lat;  // edges from start to first result
    int gap;  // edges between first and second result
    int per;
    int hi;
    int to;
    int stuck;
  } vec_t;

  // Rise sampled at edge 1 is discarded; the next is sampled at edge 1+f and
  // published S edges later. Constant low: ARM watchdog from edge 1. Constant
  // high: the single rise puts MEAS in at edge 1+S, watchdog runs from there.
  function automatic vec_t mk(input int f, input int d);
    vec_t v;
    v.freq = f;
    v.duty = d;
    if (d == 0) begin
      v.lat = 1 + TO; v.gap = TO; v.per = 0; v.hi = 0; v.to = 1; v.stuck = 0;
    end else if (d >= f) begin
      v.lat = 1 + S + TO; v.gap = TO; v.per = 0; v.hi = 0; v.to = 1; v.stuck = 1;
    end else begin
      v.lat = f + 1 + S; v.gap = f; v.per = f; v.hi = d; v.to = 0; v.stuck = 0;
    end
    return v;
  endfunction

  initial begin
    vec_t vecs[8];
    int   n, m;

    vecs[0] = mk(10, 3);
    vecs[1] = mk(16, 8);
    vecs[2] = mk(7, 1);
    vecs[3] = mk(2, 1);
    vecs[4] = mk(254, 100);  // longest measurable period
    vecs[5] = mk(254, 253);
    vecs[6] = mk(10, 0);
    vecs[7] = mk(10, 15);

    // Reset state, checked while rst_n is still low.
    #2;
    chk("reset meas_valid", int'(meas_valid), 0);
    chk_res("reset", 0, 0, 0, 0);
    chk("reset overrun", int'(overrun), 0);

    // Table of periodic sources with meas_ready held high.
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d f=%0d d=%0d", i, vecs[i].freq, vecs[i].duty);
      do_reset();
      meas_ready = 1'b1;
      start_src(vecs[i].freq, vecs[i].duty);
      wait_valid(n);
      chk({tag, " latency"}, n, vecs[i].lat);
      chk_res({tag, " first"}, vecs[i].per, vecs[i].hi, vecs[i].to, vecs[i].stuck);
      step();
      m = 1;
      while (!meas_valid && m < 600) begin
        step();
        m++;
      end
      chk({tag, " gap"}, m, vecs[i].gap);
      chk_res({tag, " second"}, vecs[i].per, vecs[i].hi, vecs[i].to, vecs[i].stuck);
    end

    // Back-pressure: first result (edge 19) held, overwritten at edges 35 and 51.
    begin
      int bad = 0;
      do_reset();
      meas_ready = 1'b0;
      start_src(16, 8);
      wait_valid(n);
      chk("bp latency", n, 19);
      for (int k = 20; k <= 34; k++) begin
        step();
        if (!meas_valid || overrun || period != 8'd16 || high_time != 8'd8) bad++;
      end
      chk("bp held stable cycles bad", bad, 0);
      step();  // edge 35
      chk("bp overrun on overwrite", int'(overrun), 1);
      repeat (24) step();  // edge 59
      chk("bp valid held", int'(meas_valid), 1);
      chk_res("bp released", 16, 8, 0, 0);
      meas_ready = 1'b1;
      step();  // edge 60: transfer, no capture
      chk("bp valid after transfer", int'(meas_valid), 0);
      chk("bp overrun sticky", int'(overrun), 1);
    end

    // meas_ready pulsed on the capture edge (captures at 13, 23, 33).
    do_reset();
    meas_ready = 1'b0;
    start_src(10, 3);
    wait_valid(n);
    repeat (9) step();  // edge 22
    meas_ready = 1'b1;
    step();  // edge 23: transfer and capture together
    meas_ready = 1'b0;
    chk("pulse valid stays", int'(meas_valid), 1);
    chk("pulse overrun clear", int'(overrun), 0);
    chk_res("pulse new", 10, 3, 0, 0);
    repeat (10) step();  // edge 33: capture onto unconsumed result
    chk("pulse later overrun", int'(overrun), 1);

    // enable low for one cycle while p_cnt=5 (capture at 23, so edge 27).
    do_reset();
    meas_ready = 1'b0;
    start_src(10, 3);
    wait_valid(n);
    repeat (10) step();  // edge 23
    chk("en overrun before", int'(overrun), 1);
    repeat (4) step();  // edge 27
    enable = 1'b0;
    step();  // edge 28
    chk("en valid cleared", int'(meas_valid), 0);
    chk("en overrun cleared", int'(overrun), 0);
    chk("en period cleared", int'(period), 0);
    chk("en high cleared", int'(high_time), 0);
    enable     = 1'b1;
    meas_ready = 1'b1;
    wait_valid(n);  // rise at 33 discarded, 43 published
    chk("en two edges latency", n, 15);
    chk_res("en after", 10, 3, 0, 0);

    // Asynchronous reset between edges, pwm low at the time.
    do_reset();
    meas_ready = 1'b0;
    start_src(10, 3);
    wait_valid(n);
    repeat (13) step();  // edge 26
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst valid", int'(meas_valid), 0);
    chk("arst overrun", int'(overrun), 0);
    chk_res("arst", 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    wait_valid(n);  // ARM at 27, rise at 33 discarded, 43 published
    chk("arst two edges latency", n, 17);

    // Random pulse trains: each pulse k (high h, low l) yields period h+l, high h.
    do_reset();
    meas_ready = 1'b1;
    enable     = 1'b1;
    repeat (5) step();
    got_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      int h, l;
      h = int'($urandom_range(1, 40));
      l = int'($urandom_range(1, 40));
      exp_q.push_back('{h + l, h, 0});
      pwm_in = 1'b1;
      repeat (h) step();
      pwm_in = 1'b0;
      repeat (l) step();
    end
    pwm_in = 1'b1;
    repeat (10) step();
    pwm_in = 1'b0;
    repeat (5) step();
    mon_en = 1'b0;
    chk("rand result count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      chk($sformatf("rand %0d period", k), got_q[k].p, exp_q[k].p);
      chk($sformatf("rand %0d high_time", k), got_q[k].h, exp_q[k].h);
      chk($sformatf("rand %0d timeout", k), got_q[k].to, exp_q[k].to);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Downstream measurement stage for the PWM generator output. It synchronises a PWM waveform and measures period and high time in clk cycles, rising edge to rising edge. Each completed measurement is published on a valid/ready result port. A stuck-level timeout covers 0% and 100% duty, which have no edges. It is used for loopback self-test of the PWM block and for capturing external PWM inputs.

Parameters:
CNT_W, 8, width of the period/high-time counters and result fields
SYNC_STAGES, 2, flops in the pwm_in synchroniser (legal range 2..4)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
enable  in  1  1 = measure; 0 = return to IDLE and clear counters and result
pwm_in  in  1  PWM waveform (may be asynchronous)
meas_valid  out  1  result register holds an unconsumed measurement
meas_ready  in  1  consumer accepts the result when meas_valid && meas_ready
period  out  CNT_W  cycles between two consecutive rising edges; 0 on timeout
high_time  out  CNT_W  cycles pwm_in was high within that period; 0 on timeout
timeout  out  1  result is a stuck-level report, not an edge measurement
stuck_level  out  1  synchronised pwm_in level at timeout; 0 otherwise
overrun  out  1  sticky: an unconsumed result was overwritten

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, counters 0, synchroniser flops 0.
- Synchroniser: SYNC_STAGES flops produce lvl; a further flop produces lvl_d.
  - rise = lvl & ~lvl_d.
- States (shared enum):
  - IDLE: entered while enable=0. Goes to ARM when enable=1.
  - ARM: waits for rise. On rise, sets p_cnt<=1 and h_cnt<=1, then goes to MEAS. No result is published for the first edge.
  - MEAS: p_cnt increments every cycle. h_cnt increments while lvl=1 and no fall has been seen since the last rise.
- On rise in MEAS:
  - Capture period=p_cnt, high_time=h_cnt, timeout=0, stuck_level=0.
  - Reload p_cnt<=1, h_cnt<=1 and stay in MEAS.
- Timeout: when p_cnt reaches 2^CNT_W-1 with no rise:
  - Capture period=0, high_time=0, timeout=1, stuck_level=lvl.
  - Go to ARM.
  - The same applies if the wait in ARM exceeds 2^CNT_W-1 cycles; ARM uses p_cnt as its watchdog.
- Latency:
  - A pwm_in rising edge first sampled at edge e gives rise during the cycle after edge e+SYNC_STAGES-1.
  - The result registers and meas_valid=1 are visible after edge e+SYNC_STAGES.
- Handshake:
  - Result fields are stable while meas_valid=1 and meas_ready=0.
  - On transfer with no new capture, meas_valid<=0.
- Simultaneous events:
  - Transfer and new capture in the same cycle: load the new result, meas_valid stays 1, overrun is unchanged.
  - New capture while meas_valid=1 and meas_ready=0: overwrite with the new result and set overrun=1. Newest result wins.
- enable deassertion, including mid-measurement, takes effect next edge:
  - Go to IDLE.
  - Clear meas_valid, overrun and the counters.
  - Synchroniser flops keep running.
- Width rules:
  - Counters are CNT_W bits unsigned and never wrap, because the timeout fires first.
  - The maximum measurable period is 2^CNT_W-2.
  - high_time <= period always holds.

Decomposition:
- Shared package pwm_pkg holds:
  - the capture state enum (IDLE, ARM, MEAS);
  - default CNT_W;
  - the localparam for the timeout threshold, all-ones of CNT_W.
- Sub-module pwm_sync_edge contains:
  - the SYNC_STAGES synchroniser, async reset;
  - the lvl_d flop;
  - outputs lvl, rise, fall.
- The FSM, counters and result register stay in pwm_capture.

Test Plan:
- PWM source with frequency=10, duty_cycle=3, meas_ready=1, enable=1 -> after the first (discarded) edge, a stream of results with period=10, high_time=3, timeout=0, one every 10 cycles.
- frequency=16, duty_cycle=8, meas_ready held 0 for 40 cycles -> first result stays stable. The second capture overwrites it and sets overrun=1. The released result reads period=16, high_time=8.
- duty_cycle=0 (constant low) -> after 255 cycles in ARM, result period=0, high_time=0, timeout=1, stuck_level=0, repeating every 255 cycles.
- duty_cycle=15, frequency=10 (constant high) -> timeout=1, stuck_level=1, no edge result.
- meas_ready pulsed exactly on the cycle a new capture lands -> meas_valid stays 1, new values present, overrun stays 0.
- Both asynchronous actions mid-MEAS, each -> counters, meas_valid and overrun clear; the next valid result requires two new rising edges:
  - deassert enable for 1 cycle at p_cnt=5;
  - separately, assert rst_n=0 asynchronously between edges (outputs 0 immediately).
